// File: rtl/alu_pkg.sv
// ALU control codes, FSM state encoding and the operand register layout
// shared by the arbiter and its alu.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU, zero latency, no flow control.
// Undefined control codes produce result 0 (and so zero = 1).
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SUB: result = a - b;
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = 32'($signed(a) >>> b[4:0]);
      ALU_SLL: result = a << b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one alu across N_REQ requesters; accept to resp_valid is 2 edges.
// One accept per 2 cycles; an unconsumed response masks its requester from arbitration.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [4*N_REQ-1:0]      req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W*N_REQ-1:0] resp_result,
  output logic [N_REQ-1:0]        resp_zero
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                tag_q, tag_d;
  alu_req_t                        opnd_q, opnd_d;
  logic [N_REQ-1:0]                resp_valid_q, resp_valid_d;
  logic [N_REQ-1:0]                resp_zero_q, resp_zero_d;
  logic [N_REQ-1:0][DATA_W-1:0]    resp_result_q, resp_result_d;

  logic [N_REQ-1:0] elig;
  logic [IDX_W:0]   pick;
  logic             win_vld;
  logic [IDX_W-1:0] win;
  logic [31:0]      alu_result;
  logic             alu_zero;

  // Returns {found, index}; scanning downward leaves the first hit at or after ptr.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (mask[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign elig    = req_valid & ~resp_valid_q;
  assign pick    = rr_pick(elig, rr_ptr_q);
  assign win_vld = pick[IDX_W];
  assign win     = pick[IDX_W-1:0];

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_vld) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    tag_d         = tag_q;
    opnd_d        = opnd_q;
    resp_valid_d  = resp_valid_q & ~resp_ready;
    resp_zero_d   = resp_zero_q;
    resp_result_d = resp_result_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          opnd_d.op = req_op[4*int'(win) +: 4];
          opnd_d.a  = req_a[DATA_W*int'(win) +: DATA_W];
          opnd_d.b  = req_b[DATA_W*int'(win) +: DATA_W];
          tag_d     = win;
          rr_ptr_d  = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        resp_result_d[tag_q] = alu_result;
        resp_zero_d[tag_q]   = alu_zero;
        resp_valid_d[tag_q]  = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      tag_q         <= '0;
      opnd_q        <= '0;
      resp_valid_q  <= '0;
      resp_zero_q   <= '0;
      resp_result_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      tag_q         <= tag_d;
      opnd_q        <= opnd_d;
      resp_valid_q  <= resp_valid_d;
      resp_zero_q   <= resp_zero_d;
      resp_result_q <= resp_result_d;
    end
  end

  alu u_alu (
    .alu_control(opnd_q.op),
    .a          (opnd_q.a),
    .b          (opnd_q.b),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  assign resp_valid  = resp_valid_q;
  assign resp_zero   = resp_zero_q;
  assign resp_result = resp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with four requesters; expected values are hand-computed.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [127:0] resp_result;
  logic [3:0]   resp_zero;

  int vectors     = 0;
  int miscompares = 0;

  alu_arbiter #(.N_REQ(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_zero  (resp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[4*i +: 4] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  logic [3:0] t2_exp [8];
  logic [3:0] t3_exp [5];
  logic [3:0] t6_exp [4];

  initial begin
    t2_exp = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    t3_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    t6_exp = '{4'b1000, 4'b0000, 4'b0010, 4'b0000};

    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = '0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_zero", resp_zero, 0);
    tick; tick;
    rst_n = 1'b1;

    // Single ADD on requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7); req_valid = 4'b0001; #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick; req_valid = '0; #1;
    chk("t1_exec_ready", req_ready, 0);
    chk("t1_not_yet", resp_valid, 0);
    tick;
    chk("t1_resp_valid", resp_valid, 4'b0001);
    chk("t1_result", resp_result[31:0], 32'd12);
    chk("t1_zero", resp_zero[0], 1'b0);
    resp_ready = 4'b0001; tick; resp_ready = '0; #1;
    chk("t1_consumed", resp_valid, 0);
    chk("t1_result_kept", resp_result[31:0], 32'd12);

    // Two requesters continuously valid, pointer starts at 1
    set_req(0, ALU_ADD, 32'd1, 32'd2); set_req(1, ALU_OR, 32'hF0, 32'h0F);
    req_valid = 4'b0011; resp_ready = 4'b0011; #1;
    for (int c = 0; c < 8; c++) begin
      chk("t2_grant", req_ready, t2_exp[c]);
      tick;
    end
    chk("t2_resp_valid", resp_valid, 4'b0001);
    chk("t2_result0", resp_result[31:0], 32'd3);
    chk("t2_result1", resp_result[63:32], 32'hFF);
    req_valid = '0; tick; resp_ready = '0; #1;
    chk("t2_drained", resp_valid, 0);

    // SUB 9-9 held on requester 1 while requester 0 keeps being served
    set_req(1, ALU_SUB, 32'd9, 32'd9); req_valid = 4'b0010; #1;
    chk("t3_ready1", req_ready, 4'b0010);
    tick; req_valid = 4'b0011; resp_ready = 4'b0001;
    tick;
    for (int c = 0; c < 5; c++) begin
      chk("t3_grant", req_ready, t3_exp[c]);
      chk("t3_hold_valid", resp_valid[1], 1'b1);
      chk("t3_hold_result", resp_result[63:32], 32'd0);
      chk("t3_hold_zero", resp_zero[1], 1'b1);
      tick;
    end
    req_valid = 4'b0010; resp_ready = 4'b0011; #1;
    chk("t3_masked", req_ready, 4'b0000);
    tick; resp_ready = '0; #1;
    chk("t3_reissue", req_ready, 4'b0010);
    chk("t3_cleared", resp_valid, 0);
    req_valid = '0; #1;

    // Undefined op 0100 on requester 0, then SRA on requester 2
    set_req(0, 4'b0100, 32'hFFFF_FFFF, 32'd0); req_valid = 4'b0001; #1;
    chk("t4_ready", req_ready, 4'b0001);
    tick; req_valid = '0; tick;
    chk("t4_valid", resp_valid, 4'b0001);
    chk("t4_result", resp_result[31:0], 32'd0);
    chk("t4_zero", resp_zero[0], 1'b1);
    resp_ready = 4'b0001; tick; resp_ready = '0;
    set_req(2, ALU_SRA, 32'h8000_0000, 32'd4); req_valid = 4'b0100; #1;
    chk("t4_sra_ready", req_ready, 4'b0100);
    tick; req_valid = '0; tick;
    chk("t4_sra_result", resp_result[95:64], 32'hF800_0000);
    chk("t4_sra_zero", resp_zero[2], 1'b0);
    resp_ready = 4'b0100; tick; resp_ready = '0;

    // Reset pulse while EXEC is in flight for requester 1 (pointer would be 2)
    set_req(1, ALU_ADD, 32'd1, 32'd1); req_valid = 4'b0010; #1;
    chk("t5_ready", req_ready, 4'b0010);
    tick; req_valid = '0;
    #2; rst_n = 1'b0; #1;
    chk("t5_rst_valid", resp_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_result", resp_result, 0);
    chk("t5_rst_zero", resp_zero, 0);
    #3; rst_n = 1'b1;
    tick;
    chk("t5_no_resp", resp_valid, 0);
    set_req(3, ALU_ADD, 32'd0, 32'd0); req_valid = 4'b1010; #1;
    chk("t5_ptr_reset", req_ready, 4'b0010);

    // Move pointer to 2, then requesters 1 and 3: grant 3, wrap, grant 1
    req_valid = 4'b0010; tick; req_valid = '0; tick;
    resp_ready = 4'b0010; tick; resp_ready = '0;
    set_req(1, ALU_AND, 32'hFF, 32'h0F); set_req(3, ALU_XOR, 32'hFF, 32'h0F);
    req_valid = 4'b1010; resp_ready = 4'b1111; #1;
    for (int c = 0; c < 4; c++) begin
      chk("t6_grant", req_ready, t6_exp[c]);
      tick;
    end
    req_valid = '0; #1;
    chk("t6_valid", resp_valid, 4'b0010);
    chk("t6_result3", resp_result[127:96], 32'hF0);
    chk("t6_result1", resp_result[63:32], 32'h0F);
    tick;
    chk("t6_drained", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
